// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared constants and helpers for the instruction fetch stage.
//               The widths match the program memory address and data ports.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    localparam int IMEM_ADDR_WIDTH  = 11;
    localparam int IMEM_DATA_WIDTH  = 32;
    localparam int INSTR_WIDTH      = IMEM_DATA_WIDTH;
    localparam int RESET_PC_DEFAULT = 0;
    localparam int PC_INCR          = 4;
    localparam int FETCH_FIFO_DEPTH = 2;

    // A byte target is word aligned only when its two low bits are zero.
    function automatic logic is_misaligned(input logic [1:0] byte_lsbs);
        return (byte_lsbs != 2'b00);
    endfunction

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous prefetch FIFO of {pc, instr} entries with
//               flush. The head is always driven from register storage.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_FIFO_DEPTH,
    parameter int AW    = IMEM_ADDR_WIDTH,
    parameter int DW    = INSTR_WIDTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [AW-1:0]    push_pc,
    input  logic [DW-1:0]    push_instr,
    output logic [CNT_W-1:0] count,
    output logic [AW-1:0]    head_pc,
    output logic [DW-1:0]    head_instr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [AW-1:0]    pc_mem    [DEPTH];
    logic [DW-1:0]    instr_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    // Only legal depths are powers of two, so pointers wrap naturally.
    generate
        if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
            $error("fetch_fifo: DEPTH must be 2 or 4");
        end
    endgenerate

    // Guard the requests so an empty pop or a full push cannot corrupt state.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL_CNT) || do_pop);
    end

    // Pointer and occupancy bookkeeping; flush discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    // Head view straight from storage.
    always_comb begin
        head_pc    = pc_mem[rd_ptr];
        head_instr = instr_mem[rd_ptr];
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Owns the PC, addresses the
//               combinational-read program memory, buffers returned words in
//               a prefetch FIFO and hands them to decode via valid/ready.
//               Supports redirect with flush and sticky misalign detection.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = INSTR_WIDTH,
    parameter int RESET_PC   = RESET_PC_DEFAULT,
    parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  misalign_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] RST_PC   = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] INCR     = ADDR_WIDTH'(PC_INCR);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [CNT_W-1:0]      count;
    logic                  pop;
    logic                  push;

    // Redirect wins: it suppresses both the pop and the push of its cycle.
    always_comb begin
        out_valid = (count != '0);
        pop       = out_valid && out_ready && !redirect_valid;
        push      = fetch_en && !redirect_valid && ((count != FULL_CNT) || pop);
        imem_addr = fetch_pc;
    end

    // Program counter: aligned redirect target, else sequential advance on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RST_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (push) begin
            fetch_pc <= fetch_pc + INCR;
        end
    end

    // Sticky misaligned-target flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && is_misaligned(redirect_pc[1:0])) begin
            misalign_err <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (ADDR_WIDTH),
        .DW    (DATA_WIDTH),
        .CNT_W (CNT_W)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .pop        (pop),
        .push_pc    (fetch_pc),
        .push_instr (imem_rdata),
        .count      (count),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch with a
//               combinational program memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        fetch_en;
    logic        redirect_valid;
    logic [10:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [10:0] out_pc;
    logic        misalign_err;

    int total_cnt;
    int pass_cnt;

    logic [31:0] mem [512];

    instr_fetch #(
        .ADDR_WIDTH (11),
        .DATA_WIDTH (32),
        .RESET_PC   (0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational-read program memory.
    assign imem_rdata = mem[imem_addr[10:2]];

    // Expected word stored at a byte address (hand-built table rule).
    function automatic logic [31:0] word_at(input logic [10:0] a);
        if (a == 11'h000) return 32'h0000_0013;
        if (a == 11'h004) return 32'h0010_0093;
        return 32'hA500_0000 | {21'd0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [10:0] pc);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_pc"},    {21'd0, out_pc},    {21'd0, pc});
        check({tag, "_instr"}, out_instr,          word_at(pc));
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        for (int i = 0; i < 512; i++) begin
            mem[i] = word_at(11'(i * 4));
        end

        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 11'h000;

        // Reset state.
        tick();
        tick();
        check("rst_valid",    {31'd0, out_valid},    32'd0);
        check("rst_addr",     {21'd0, imem_addr},    32'h000);
        check("rst_pc",       {21'd0, out_pc},       32'h000);
        check("rst_instr",    out_instr,             32'h0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);

        // Release; first edge pushes RESET_PC, then one per cycle.
        rst_n = 1'b1;
        tick();
        check_head("first", 11'h000);
        check("first_addr", {21'd0, imem_addr}, 32'h004);
        tick();
        check_head("second", 11'h004);

        // Stall: one more push fills the FIFO, then the PC freezes.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_head("stall", 11'h004);
            check("stall_addr", {21'd0, imem_addr}, 32'h00C);
        end

        // Release the stall: in-order drain with no bubble.
        out_ready = 1'b1;
        tick();
        check_head("drain0", 11'h008);
        tick();
        check_head("drain1", 11'h00C);
        tick();
        check_head("drain2", 11'h010);

        // Redirect while full: flush, one bubble, then target.
        redirect_valid = 1'b1;
        redirect_pc    = 11'h100;
        tick();
        redirect_valid = 1'b0;
        check("redir_bubble", {31'd0, out_valid}, 32'd0);
        check("redir_addr",   {21'd0, imem_addr}, 32'h100);
        tick();
        check_head("redir_tgt", 11'h100);
        tick();
        check_head("redir_next", 11'h104);
        check("aligned_no_err", {31'd0, misalign_err}, 32'd0);

        // Misaligned redirect: sticky error, fetch at aligned address.
        redirect_valid = 1'b1;
        redirect_pc    = 11'h102;
        tick();
        redirect_valid = 1'b0;
        check("mis_err",    {31'd0, misalign_err}, 32'd1);
        check("mis_bubble", {31'd0, out_valid},    32'd0);
        check("mis_addr",   {21'd0, imem_addr},    32'h100);
        tick();
        check_head("mis_tgt", 11'h100);
        check("mis_sticky", {31'd0, misalign_err}, 32'd1);

        // Wrap from the top word back to zero.
        redirect_valid = 1'b1;
        redirect_pc    = 11'h7FC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr0", {21'd0, imem_addr}, 32'h7FC);
        tick();
        check_head("wrap_top", 11'h7FC);
        check("wrap_addr1", {21'd0, imem_addr}, 32'h000);
        tick();
        check_head("wrap_zero", 11'h000);
        check("wrap_sticky", {31'd0, misalign_err}, 32'd1);

        // fetch_en low: FIFO drains, PC holds.
        fetch_en = 1'b0;
        tick();
        check("fen_empty", {31'd0, out_valid}, 32'd0);
        check("fen_addr0", {21'd0, imem_addr}, 32'h004);
        tick();
        check("fen_addr1", {21'd0, imem_addr}, 32'h004);
        check("fen_empty1", {31'd0, out_valid}, 32'd0);

        // Refill to full, then assert reset mid-cycle.
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        check_head("full_head", 11'h004);
        check("full_addr", {21'd0, imem_addr}, 32'h00C);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",    {31'd0, out_valid},    32'd0);
        check("arst_addr",     {21'd0, imem_addr},    32'h000);
        check("arst_pc",       {21'd0, out_pc},       32'h000);
        check("arst_misalign", {31'd0, misalign_err}, 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check_head("post_rst", 11'h000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the program memory and downstream-facing to decode. Owns the program counter, drives the byte address into the combinational-read program memory, captures the returned (already byte-order-corrected) instruction word into a 2-entry prefetch FIFO, and presents instructions to decode over a valid/ready handshake. Supports PC redirect (branch/jump/trap) with flush, fetch enable, and misaligned-target detection.

## Interface
- ADDR_WIDTH, 11, byte-address width; matches program memory address port.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, byte address fetched first after reset; must be word aligned.
- FIFO_DEPTH, 2, prefetch entries (legal values 2 or 4).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_WIDTH  byte address to program memory; equals fetch_pc.
- imem_rdata  in  DATA_WIDTH  instruction word from program memory, valid combinationally in the same cycle as imem_addr.
- fetch_en  in  1  1 = fetching allowed; 0 = no new pushes, FIFO still drains.
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  redirect byte target.
- out_valid  out  1  out_instr/out_pc hold a valid instruction.
- out_ready  in  1  decode accepts the head entry this cycle.
- out_instr  out  DATA_WIDTH  instruction at FIFO head.
- out_pc  out  ADDR_WIDTH  byte address of out_instr.
- misalign_err  out  1  sticky; set when a redirect target has redirect_pc[1:0] != 0.

## Operation
- State: fetch_pc register, FIFO (entries {pc, instr}), count 0..FIFO_DEPTH, misalign_err.
- pop = out_valid && out_ready.
- push = fetch_en && !redirect_valid && (count < FIFO_DEPTH || pop). On push the entry {fetch_pc, imem_rdata} is written at tail and fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_WIDTH (max word address wraps to 0).
- Simultaneous push and pop at full: allowed; count unchanged, no bubble.
- Redirect (highest priority): FIFO flushed (count <= 0), any pop/push that cycle discarded, fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}. If redirect_pc[1:0] != 0, misalign_err <= 1 (cleared only by reset); fetch continues at aligned address.
- out_valid = (count != 0); out_instr/out_pc come from head register storage, never combinationally from imem_rdata.
- Head entry must remain stable while out_valid && !out_ready.
- fetch_pc[1:0] is always 0.
- fetch_en low: fetch_pc holds; FIFO drains normally; redirect still honoured.

## Timing
- Reset (async assert, sync release): fetch_pc = RESET_PC, imem_addr = RESET_PC, count = 0, out_valid = 0, out_instr = 0, out_pc = 0, misalign_err = 0.
- Fetch latency: address presented in cycle N → instruction visible at out_valid in cycle N+1.
- First edge after reset release with fetch_en = 1: push RESET_PC; out_valid = 1 with out_pc = RESET_PC next cycle.
- Redirect sampled at edge N: out_valid = 0 during cycle N+1 (imem_addr = target), target instruction at head in cycle N+2. Redirect penalty: exactly one bubble.
- Sustained throughput 1 instruction/cycle with out_ready held high.
- Reset mid-operation: all state returns to reset values immediately, FIFO contents lost.

## Structure
- Shared package: INSTR_WIDTH, RESET_PC default, PC_INCR = 4, FIFO depth constant; same ADDR/DATA width defines as program memory.
- One sub-module: fetch_fifo (parameterised synchronous FIFO with flush, push, pop, count, head outputs); instr_fetch holds PC, push/redirect control, error flag.

## Test plan
- Reset release, fetch_en = 1, out_ready = 1, memory words 0x00000013, 0x00100093 at 0x0, 0x4 → out_pc 0x0 then 0x4 on consecutive cycles, no bubbles.
- out_ready = 0 for 5 cycles → count saturates at 2, fetch_pc stops at 0x8, out_instr/out_pc stable at 0x0 entry; ready high → 0x0, 0x4, 0x8 in order.
- redirect_valid with redirect_pc = 0x100 while FIFO full → FIFO flushed, one cycle out_valid = 0, then out_pc = 0x100.
- redirect_pc = 0x102 → misalign_err = 1 from next cycle and stays set, fetch resumes at 0x100.
- fetch_pc at 0x7FC (ADDR_WIDTH = 11) → next out_pc 0x000 (wrap).
- rst_n asserted mid-stream with FIFO full → out_valid = 0, imem_addr = RESET_PC in same cycle as assertion.
